// File: rtl/pim_bridge_pkg.sv
// Shared types and constants for the core-to-PIM request bridge.
package pim_bridge_pkg;

   // Bridge FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } pim_br_state_e;

   // One queued core request
   typedef struct packed {
      logic        we;
      logic [29:0] addr;
      logic [31:0] wdata;
   } pim_req_t;

   // Bit positions inside the PIM command word
   localparam int unsigned PIM_VALID_BIT = 31;
   localparam int unsigned PIM_WE_BIT    = 30;

   // Build the PIM command word for a request: valid flag, write flag, word address.
   function automatic logic [31:0] pim_cmd(input pim_req_t req);
      logic [31:0] cmd;
      cmd                = '0;
      cmd[PIM_VALID_BIT] = 1'b1;
      cmd[PIM_WE_BIT]    = req.we;
      cmd[29:0]          = req.addr;
      return cmd;
   endfunction

   // Larger of two unsigned values, used for counter sizing.
   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pim_req_fifo.sv
// In-order request FIFO with wrapping pointers and an explicit occupancy count.
module pim_req_fifo
   import pim_bridge_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic     i_clk,
   input  logic     i_rst,
   input  logic     i_push,
   input  pim_req_t i_data,
   input  logic     i_pop,
   output pim_req_t o_data,
   output logic     o_full,
   output logic     o_empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   pim_req_t         mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   // Guard both ports so a stray push/pop can never corrupt the pointers
   always_comb begin
      do_push = i_push & ~o_full;
      do_pop  = i_pop & ~o_empty;
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at power-of-two depth
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage write; contents need no reset because count gates visibility
   always_ff @(posedge i_clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= i_data;
      end
   end

   // Head-of-queue view and status flags derived from registered state
   always_comb begin
      o_data  = mem[rd_ptr_q];
      o_full  = (count_q == FULL_CNT);
      o_empty = (count_q == '0);
   end

endmodule

// File: rtl/pim_req_bridge.sv
// Core PIM port to PIM macro bridge: queues requests, holds each command on the
// unhandshaked PIM bus for fixed cycle counts and returns read data over valid/ready.
module pim_req_bridge
   import pim_bridge_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned ISSUE_CYCLES = 1,
   parameter int unsigned RD_LATENCY   = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_rdata,
   output logic        o_busy,
   output logic [31:0] o_pim_addr,
   output logic [31:0] o_pim_wr_data,
   input  logic [31:0] i_pim_rd_data
);

   localparam int unsigned MAX_HOLD = max_u(ISSUE_CYCLES, RD_LATENCY);
   localparam int unsigned CNT_W    = $clog2(MAX_HOLD + 1);
   // Counter counts down to zero, so load hold-1
   localparam logic [CNT_W-1:0] ISSUE_LOAD = CNT_W'(ISSUE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(RD_LATENCY - 1);

   pim_br_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      cmd_q, cmd_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             armed_q;

   pim_req_t  push_data;
   pim_req_t  head;
   logic      push;
   logic      pop;
   logic      fifo_full;
   logic      fifo_empty;
   logic [1:0] unused_addr_hi;

   // Top address bits are not part of the PIM address space
   assign unused_addr_hi = i_req_addr[31:30];

   // Accept a request whenever there is room and reset has been released
   always_comb begin
      o_req_ready     = armed_q & ~fifo_full;
      push            = i_req_valid & o_req_ready;
      push_data.we    = i_req_we;
      push_data.addr  = i_req_addr[29:0];
      push_data.wdata = i_req_wdata;
   end

   pim_req_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (push),
      .i_data  (push_data),
      .i_pop   (pop),
      .o_data  (head),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   // Next-state logic: pop, hold command, optionally wait for read data, hand back response
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_d       = cmd_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      rsp_valid_d = rsp_valid_q;
      pop         = 1'b0;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               cmd_d   = pim_cmd(head);
               // Write data bus keeps its last write value across reads
               if (head.we) begin
                  wdata_d = head.wdata;
               end
               cnt_d   = ISSUE_LOAD;
               state_d = ISSUE;
            end
         end

         ISSUE: begin
            if (cnt_q == '0) begin
               if (cmd_q[PIM_WE_BIT]) begin
                  // Writes are posted: drop the command and go fetch the next one
                  cmd_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d   = WAIT_LOAD;
                  state_d = WAIT;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         WAIT: begin
            if (cnt_q == '0) begin
               cmd_d       = '0;
               rdata_d     = i_pim_rd_data;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         RESP: begin
            // Response stays put until the core takes it; nothing else issues meanwhile
            if (i_rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            cmd_d       = '0;
            rsp_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State and output registers; reset discards any in-flight command or response
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cmd_q       <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_q       <= cmd_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // Holds ready low while reset is asserted and releases it on the first clock after
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         armed_q <= 1'b0;
      end else begin
         armed_q <= 1'b1;
      end
   end

   // Output mapping from registered state
   always_comb begin
      o_pim_addr    = cmd_q;
      o_pim_wr_data = wdata_q;
      o_rsp_rdata   = rdata_q;
      o_rsp_valid   = rsp_valid_q;
      o_busy        = (state_q != IDLE) | ~fifo_empty;
   end

endmodule

// File: tb/tb_pim_req_bridge.sv
// Scoreboard bench for pim_req_bridge with default parameters.
module tb_pim_req_bridge;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_req_valid;
   logic        o_req_ready;
   logic        i_req_we;
   logic [31:0] i_req_addr;
   logic [31:0] i_req_wdata;
   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [31:0] o_rsp_rdata;
   logic        o_busy;
   logic [31:0] o_pim_addr;
   logic [31:0] o_pim_wr_data;
   logic [31:0] i_pim_rd_data;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      int          hold;
   } cmd_exp_t;

   cmd_exp_t    cmd_q [$];
   logic [31:0] rsp_q [$];
   int          tests = 0;
   int          fails = 0;

   // Monitor state
   bit          mon_cmd_act = 1'b0;
   int          mon_hold = 0;
   cmd_exp_t    mon_cur;
   bit          mon_rv_prev = 1'b0;
   bit          mon_hs_prev = 1'b0;
   logic [31:0] mon_rd_prev = '0;

   always #5 i_clk = ~i_clk;

   pim_req_bridge dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_req_valid   (i_req_valid),
      .o_req_ready   (o_req_ready),
      .i_req_we      (i_req_we),
      .i_req_addr    (i_req_addr),
      .i_req_wdata   (i_req_wdata),
      .o_rsp_valid   (o_rsp_valid),
      .i_rsp_ready   (i_rsp_ready),
      .o_rsp_rdata   (o_rsp_rdata),
      .o_busy        (o_busy),
      .o_pim_addr    (o_pim_addr),
      .o_pim_wr_data (o_pim_wr_data),
      .i_pim_rd_data (i_pim_rd_data)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Drive a request and record what the PIM bus and response channel must show
   task automatic set_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd);
      cmd_exp_t e;
      e.addr  = {1'b1, we, addr[29:0]};
      e.wdata = wdata;
      e.hold  = we ? 1 : 3;
      cmd_q.push_back(e);
      if (!we) rsp_q.push_back(exp_rd);
      i_req_valid = 1'b1;
      i_req_we    = we;
      i_req_addr  = addr;
      i_req_wdata = wdata;
   endtask

   // Wait (bounded) for the accepting edge; returns at #1 after it
   task automatic wait_accept();
      int n = 0;
      forever begin
         @(negedge i_clk);
         if (o_req_ready) break;
         n++;
         if (n > 60) begin
            $display("FAIL push_timeout: got ready=0 expected ready=1");
            fails++;
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $fatal(1, "request never accepted");
         end
      end
      @(posedge i_clk);
      #1;
      i_req_valid = 1'b0;
   endtask

   task automatic push_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rd);
      set_req(we, addr, wdata, exp_rd);
      wait_accept();
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((o_busy || o_rsp_valid || cmd_q.size() != 0 || rsp_q.size() != 0) && n < 200) begin
         tick();
         n++;
      end
      chk(name, 32'(n < 200), 1);
   endtask

   // Monitor: checks every PIM command and every response against the queues
   initial begin
      forever begin
         @(negedge i_clk);
         if (i_rst) begin
            mon_cmd_act = 1'b0;
            mon_rv_prev = 1'b0;
            mon_hs_prev = 1'b0;
         end else begin
            if (o_pim_addr[31]) begin
               if (!mon_cmd_act) begin
                  if (cmd_q.size() == 0) begin
                     chk("unexpected_cmd", o_pim_addr, 0);
                  end else begin
                     mon_cur     = cmd_q.pop_front();
                     mon_hold    = 1;
                     mon_cmd_act = 1'b1;
                     chk("cmd_addr", o_pim_addr, mon_cur.addr);
                     if (mon_cur.addr[30]) chk("cmd_wdata", o_pim_wr_data, mon_cur.wdata);
                  end
               end else begin
                  mon_hold++;
                  chk("cmd_held_addr", o_pim_addr, mon_cur.addr);
               end
            end else if (mon_cmd_act) begin
               mon_cmd_act = 1'b0;
               chk("cmd_hold_len", 32'(mon_hold), 32'(mon_cur.hold));
            end

            if (o_rsp_valid) begin
               if (mon_rv_prev && !mon_hs_prev) chk("rsp_stable", o_rsp_rdata, mon_rd_prev);
               if (rsp_q.size() == 0) begin
                  chk("unexpected_rsp", {31'b0, o_rsp_valid}, 0);
               end else if (i_rsp_ready) begin
                  chk("rsp_data", o_rsp_rdata, rsp_q.pop_front());
               end
            end
            mon_rv_prev = o_rsp_valid;
            mon_hs_prev = o_rsp_valid && i_rsp_ready;
            mon_rd_prev = o_rsp_rdata;
         end
      end
   end

   // Directed stimulus
   initial begin
      int n;
      i_rst         = 1'b1;
      i_req_valid   = 1'b0;
      i_req_we      = 1'b0;
      i_req_addr    = '0;
      i_req_wdata   = '0;
      i_rsp_ready   = 1'b1;
      i_pim_rd_data = '0;

      // Reset state
      #12;
      chk("rst_pim_addr", o_pim_addr, 0);
      chk("rst_wr_data", o_pim_wr_data, 0);
      chk("rst_rdata", o_rsp_rdata, 0);
      chk("rst_rsp_valid", {31'b0, o_rsp_valid}, 0);
      chk("rst_busy", {31'b0, o_busy}, 0);
      chk("rst_ready_during", {31'b0, o_req_ready}, 0);
      @(negedge i_clk);
      i_rst = 1'b0;
      tick();
      chk("rst_ready_after", {31'b0, o_req_ready}, 1);

      // Single write: command for exactly one cycle at T+2
      push_req(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 0);
      chk("wr_busy_t1", {31'b0, o_busy}, 1);
      chk("wr_addr_t1", o_pim_addr, 0);
      tick();
      chk("wr_addr_t2", o_pim_addr, 32'hC000_0040);
      chk("wr_data_t2", o_pim_wr_data, 32'hDEAD_BEEF);
      tick();
      chk("wr_addr_t3", o_pim_addr, 0);
      chk("wr_busy_t3", {31'b0, o_busy}, 0);
      repeat (3) tick();
      chk("wr_no_rsp", {31'b0, o_rsp_valid}, 0);

      // Single read: command T+2..T+4, response at T+5
      i_pim_rd_data = 32'h1234_5678;
      push_req(1'b0, 32'h0000_0010, 0, 32'h1234_5678);
      chk("rd_addr_t1", o_pim_addr, 0);
      for (int k = 2; k <= 4; k++) begin
         tick();
         chk("rd_addr_hold", o_pim_addr, 32'h8000_0010);
         chk("rd_no_rsp_yet", {31'b0, o_rsp_valid}, 0);
      end
      tick();
      chk("rd_rsp_valid_t5", {31'b0, o_rsp_valid}, 1);
      chk("rd_rsp_data_t5", o_rsp_rdata, 32'h1234_5678);
      chk("rd_addr_t5", o_pim_addr, 0);
      tick();
      chk("rd_rsp_done", {31'b0, o_rsp_valid}, 0);

      // Fill FIFO while stalled in RESP, with response backpressure
      i_rsp_ready   = 1'b0;
      i_pim_rd_data = 32'hA5A5_0001;
      push_req(1'b0, 32'h0000_0020, 0, 32'hA5A5_0001);
      n = 0;
      while (!o_rsp_valid && n < 20) begin
         tick();
         n++;
      end
      chk("stall_rsp_seen", {31'b0, o_rsp_valid}, 1);
      i_pim_rd_data = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) push_req(1'b1, 32'h200 + 32'(4 * i), 32'hBEEF_0000 + 32'(i), 0);
      chk("fill_ready_low", {31'b0, o_req_ready}, 0);
      set_req(1'b1, 32'h210, 32'hBEEF_0004, 0);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("fill_ready_stays_low", {31'b0, o_req_ready}, 0);
         chk("bp_rsp_valid", {31'b0, o_rsp_valid}, 1);
         chk("bp_rsp_data", o_rsp_rdata, 32'hA5A5_0001);
         chk("bp_no_issue", o_pim_addr, 0);
      end
      i_rsp_ready = 1'b1;
      wait_accept();
      wait_idle("fill_drain");
      chk("fill_ready_back", {31'b0, o_req_ready}, 1);

      // Full-rate stream of 8 writes through pointer wrap
      for (int i = 0; i < 8; i++) push_req(1'b1, 32'h300 + 32'(4 * i), 32'h5A00_0000 + 32'(i), 0);
      wait_idle("stream_drain");

      // Reset in the middle of a read
      i_pim_rd_data = 32'h0BAD_F00D;
      push_req(1'b0, 32'h0000_0030, 0, 32'h0BAD_F00D);
      tick();
      tick();
      chk("mid_rd_wait_addr", o_pim_addr, 32'h8000_0030);
      #1;
      i_rst = 1'b1;
      #1;
      rsp_q.delete();
      cmd_q.delete();
      chk("mid_rst_pim_addr", o_pim_addr, 0);
      chk("mid_rst_wr_data", o_pim_wr_data, 0);
      chk("mid_rst_rsp_valid", {31'b0, o_rsp_valid}, 0);
      chk("mid_rst_busy", {31'b0, o_busy}, 0);
      chk("mid_rst_ready", {31'b0, o_req_ready}, 0);
      @(negedge i_clk);
      i_rst = 1'b0;
      tick();
      chk("mid_rst_ready_after", {31'b0, o_req_ready}, 1);
      chk("mid_rst_empty", {31'b0, o_busy}, 0);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("no_stale_rsp", {31'b0, o_rsp_valid}, 0);
      end

      // Bridge still works after reset
      i_pim_rd_data = 32'hCAFE_F00D;
      push_req(1'b0, 32'h0000_0044, 0, 32'hCAFE_F00D);
      wait_idle("post_rst_read");

      repeat (3) tick();
      chk("cmd_queue_empty", 32'(cmd_q.size()), 0);
      chk("rsp_queue_empty", 32'(rsp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
